// File: rtl/z16_pkg.sv
// Shared definitions for the Z16 issue/writeback sequencer: opcodes, ALU
// control encodings, FSM states and instruction field positions.
package z16_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    // Instruction field slice positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;

    // ALU control encodings (identical to the ALU opcodes)
    localparam logic [3:0] CTRL_ADD = 4'h0;
    localparam logic [3:0] CTRL_SUB = 4'h1;
    localparam logic [3:0] CTRL_MUL = 4'h2;
    localparam logic [3:0] CTRL_DIV = 4'h3;
    localparam logic [3:0] CTRL_OR  = 4'h4;
    localparam logic [3:0] CTRL_AND = 4'h5;
    localparam logic [3:0] CTRL_XOR = 4'h6;
    localparam logic [3:0] CTRL_SHL = 4'h7;
    localparam logic [3:0] CTRL_SHR = 4'h8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // True for opcodes that go through the external ALU
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_SHR);
    endfunction

    // ALU control for an opcode; LDI and illegal opcodes drive ADD (0)
    function automatic logic [3:0] alu_ctrl_of(input logic [3:0] op);
        logic [3:0] ctrl;
        case (op)
            OP_ADD:  ctrl = CTRL_ADD;
            OP_SUB:  ctrl = CTRL_SUB;
            OP_MUL:  ctrl = CTRL_MUL;
            OP_DIV:  ctrl = CTRL_DIV;
            OP_OR:   ctrl = CTRL_OR;
            OP_AND:  ctrl = CTRL_AND;
            OP_XOR:  ctrl = CTRL_XOR;
            OP_SHL:  ctrl = CTRL_SHL;
            OP_SHR:  ctrl = CTRL_SHR;
            default: ctrl = CTRL_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/z16_regfile.sv
// 16x16 register file: two asynchronous read ports, one synchronous write
// port, synchronous active-low clear of every register.
module z16_regfile
    import z16_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              we,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NREG];

    // Clear takes priority over the write, so a reset in WB drops the write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read ports
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
    end

endmodule

// File: rtl/z16_alu_issue.sv
// Z16 issue/writeback sequencer. Accepts one instruction per four cycles,
// reads operands, drives the external combinational ALU and writes the
// result (or the LDI / divide-by-zero substitute) back to rd.
//
// Handshake: an instruction transfers on a rising edge where i_inst_valid
// and o_inst_ready are both high; i_inst is sampled only at that edge.
module z16_alu_issue
    import z16_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inst_valid,
    input  logic [15:0] i_inst,
    output logic        o_inst_ready,
    output logic [15:0] o_alu_a,
    output logic [15:0] o_alu_b,
    output logic [3:0]  o_alu_ctrl,
    input  logic [15:0] i_alu_result,
    output logic        o_wb_valid,
    output logic [3:0]  o_wb_addr,
    output logic [15:0] o_wb_data,
    output logic        o_err
);

    state_t      state;
    logic [15:0] inst_q;

    logic [3:0]  op_q;
    logic [3:0]  rd_q;
    logic [3:0]  rs1_q;
    logic [3:0]  rs2_q;
    logic [7:0]  imm_q;

    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic        rf_we;

    logic        exec_wr;
    logic        exec_err;
    logic [15:0] exec_data;

    assign op_q  = inst_q[OP_MSB:OP_LSB];
    assign rd_q  = inst_q[RD_MSB:RD_LSB];
    assign rs1_q = inst_q[RS1_MSB:RS1_LSB];
    assign rs2_q = inst_q[RS2_MSB:RS2_LSB];
    assign imm_q = inst_q[IMM_MSB:IMM_LSB];

    // The write lands at the end of the WB cycle using the registered WB outputs
    assign rf_we = (state == S_WB) && o_wb_valid;

    z16_regfile #(
        .NREG (NREG)
    ) u_regfile (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .rd_addr_a (rs1_q),
        .rd_data_a (rs1_data),
        .rd_addr_b (rs2_q),
        .rd_data_b (rs2_data),
        .we        (rf_we),
        .wr_addr   (o_wb_addr),
        .wr_data   (o_wb_data)
    );

    // EXEC-cycle result selection: ALU result, LDI immediate or error substitute
    always_comb begin
        exec_wr   = 1'b1;
        exec_err  = 1'b0;
        exec_data = i_alu_result;
        if (op_q == OP_LDI) begin
            exec_data = {8'h00, imm_q};
        end else if (!is_alu_op(op_q)) begin
            exec_wr  = 1'b0;
            exec_err = 1'b1;
        end else if ((op_q == OP_DIV) && (o_alu_a == 16'h0000)) begin
            exec_data = 16'hFFFF;
            exec_err  = 1'b1;
        end
    end

    // Sequencer FSM with registered handshake, ALU and writeback outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            inst_q       <= '0;
            o_inst_ready <= 1'b1;
            o_alu_a      <= '0;
            o_alu_b      <= '0;
            o_alu_ctrl   <= '0;
            o_wb_valid   <= 1'b0;
            o_wb_addr    <= '0;
            o_wb_data    <= '0;
            o_err        <= 1'b0;
        end else begin
            o_wb_valid <= 1'b0;
            o_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_inst_valid && o_inst_ready) begin
                        inst_q       <= i_inst;
                        o_inst_ready <= 1'b0;
                        state        <= S_READ;
                    end
                end
                S_READ: begin
                    // Operand A comes from rs2 and B from rs1
                    o_alu_a    <= rs2_data;
                    o_alu_b    <= rs1_data;
                    o_alu_ctrl <= alu_ctrl_of(op_q);
                    state      <= S_EXEC;
                end
                S_EXEC: begin
                    o_wb_valid <= exec_wr;
                    o_err      <= exec_err;
                    if (exec_wr) begin
                        o_wb_addr <= rd_q;
                        o_wb_data <= exec_data;
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    o_inst_ready <= 1'b1;
                    state        <= S_IDLE;
                end
                default: begin
                    o_inst_ready <= 1'b1;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule
